// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word width,
// fetch FSM encoding and the NOP bubble value presented to decode.
package if_fetch_stage_pkg;

  localparam int unsigned IF_WORD_LEN = 32;

  // Value that fills the IF/ID register whenever it holds no real instruction.
  localparam logic [31:0] NOP_BUBBLE = 32'd0;

  // FETCH: request outstanding at pc
  // HOLD : a fetched word is parked while decode is frozen
  // DROP : a wrong-path request is still in flight and must be swallowed
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID boundary register. Flush puts the NOP bubble in, load captures a
// new instruction/PC+4 pair, and with neither the contents are held.
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned WORD_LEN = IF_WORD_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] load_instr,
  input  logic [WORD_LEN-1:0] load_pc,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_out,
  output logic                valid_out
);

  // Boundary register update: reset and flush both insert the bubble; flush beats load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instruction <= WORD_LEN'(NOP_BUBBLE);
      pc_out      <= {WORD_LEN{1'b0}};
      valid_out   <= 1'b0;
    end else if (load) begin
      instruction <= load_instr;
      pc_out      <= load_pc;
      valid_out   <= 1'b1;
    end else begin
      instruction <= instruction;
      pc_out      <= pc_out;
      valid_out   <= valid_out;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the req/ack instruction
// memory port and feeds the IF/ID register. Handles decode freeze and
// taken-branch redirect, swallowing wrong-path fetches still in flight.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned          WORD_LEN = IF_WORD_LEN,
  parameter logic [WORD_LEN-1:0]  RESET_PC = {WORD_LEN{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                brTaken,
  input  logic [WORD_LEN-1:0] br_offset,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] pc_out,
  output logic                valid_out
);

  fetch_state_e        state_r, state_nxt_s;
  logic [WORD_LEN-1:0] pc_r, pc_nxt_s;
  logic [WORD_LEN-1:0] pending_pc_r, pending_pc_nxt_s;
  logic [WORD_LEN-1:0] hold_instr_r, hold_instr_nxt_s;
  logic [WORD_LEN-1:0] hold_pc_r, hold_pc_nxt_s;
  logic                imem_req_r, req_nxt_s;
  logic [WORD_LEN-1:0] imem_addr_r, addr_nxt_s;
  logic [WORD_LEN-1:0] pc_plus4_s, target_s;
  logic                ifid_load_s, ifid_flush_s;
  logic [WORD_LEN-1:0] ifid_instr_s, ifid_pc_s;

  assign pc_plus4_s = pc_r + WORD_LEN'(3'd4);
  // pc_out carries the branch's own PC+4; the sum wraps at the word width.
  assign target_s   = pc_out + (br_offset << 2);
  assign imem_req   = imem_req_r;
  assign imem_addr  = imem_addr_r;

  // Next-state, PC, hold-buffer and IF/ID control decode; priority is brTaken over freeze.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    pending_pc_nxt_s = pending_pc_r;
    hold_instr_nxt_s = hold_instr_r;
    hold_pc_nxt_s    = hold_pc_r;
    ifid_load_s      = 1'b0;
    ifid_flush_s     = 1'b0;
    ifid_instr_s     = imem_rdata;
    ifid_pc_s        = pc_plus4_s;
    case (state_r)
      FETCH: begin
        if (brTaken) begin
          ifid_flush_s = 1'b1;
          if (imem_ack) begin
            pc_nxt_s = target_s;
          end else begin
            pending_pc_nxt_s = target_s;
            state_nxt_s      = DROP;
          end
        end else if (imem_ack) begin
          pc_nxt_s = pc_plus4_s;
          if (freeze) begin
            hold_instr_nxt_s = imem_rdata;
            hold_pc_nxt_s    = pc_plus4_s;
            state_nxt_s      = HOLD;
          end else begin
            ifid_load_s = 1'b1;
          end
        end else if (!freeze) begin
          ifid_flush_s = 1'b1;
        end else begin
          ifid_flush_s = 1'b0;
        end
      end
      HOLD: begin
        if (brTaken) begin
          ifid_flush_s = 1'b1;
          pc_nxt_s     = target_s;
          state_nxt_s  = FETCH;
        end else if (!freeze) begin
          ifid_load_s  = 1'b1;
          ifid_instr_s = hold_instr_r;
          ifid_pc_s    = hold_pc_r;
          state_nxt_s  = FETCH;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DROP: begin
        // The stale response never reaches decode, frozen or not.
        ifid_flush_s = 1'b1;
        if (brTaken) begin
          pending_pc_nxt_s = target_s;
        end else begin
          pending_pc_nxt_s = pending_pc_r;
        end
        if (imem_ack) begin
          pc_nxt_s    = brTaken ? target_s : pending_pc_r;
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        ifid_flush_s = 1'b1;
        state_nxt_s  = FETCH;
      end
    endcase
    // The request address only moves when no request is left waiting.
    req_nxt_s  = (state_nxt_s != HOLD);
    addr_nxt_s = (state_nxt_s == DROP) ? imem_addr_r : pc_nxt_s;
  end

  // Fetch-side state registers, including the registered memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      pending_pc_r <= {WORD_LEN{1'b0}};
      hold_instr_r <= {WORD_LEN{1'b0}};
      hold_pc_r    <= {WORD_LEN{1'b0}};
      imem_req_r   <= 1'b1;
      imem_addr_r  <= RESET_PC;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pending_pc_r <= pending_pc_nxt_s;
      hold_instr_r <= hold_instr_nxt_s;
      hold_pc_r    <= hold_pc_nxt_s;
      imem_req_r   <= req_nxt_s;
      imem_addr_r  <= addr_nxt_s;
    end
  end

  if_fetch_stage_if_id_reg #(
    .WORD_LEN (WORD_LEN)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (ifid_load_s),
    .flush       (ifid_flush_s),
    .load_instr  (ifid_instr_s),
    .load_pc     (ifid_pc_s),
    .instruction (instruction),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a bench-side instruction memory with
// configurable wait states (rdata = addr + 100) and a scoreboard of the
// instructions decode is expected to receive, in order.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        brTaken = 1'b0;
  logic [31:0] br_offset = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid_out;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          waits = 0;
  int          wait_cnt = 0;
  bit          waiting = 1'b0;
  logic [31:0] wait_addr = 32'd0;
  bit          prev_valid = 1'b0;
  logic [31:0] prev_instr = 32'd0;
  logic [31:0] prev_pc = 32'd0;

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .brTaken     (brTaken),
    .br_offset   (br_offset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_out      (pc_out),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: memory answers at the negedge, outputs sampled 1 unit after posedge.
  // accept=1 means an ack this cycle is a word decode must eventually see.
  task automatic step(input bit accept);
    exp_t e;
    @(negedge clk);
    imem_ack = 1'b0;
    if (imem_req && !rst) begin
      if (waiting) check("addr_stable", imem_addr, wait_addr);
      if (wait_cnt >= waits) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr + 32'd100;
        wait_cnt   = 0;
        waiting    = 1'b0;
        if (accept) begin
          e.instr = imem_addr + 32'd100;
          e.pc    = imem_addr + 32'd4;
          sb.push_back(e);
        end
      end else begin
        wait_cnt++;
        if (!waiting) begin
          waiting   = 1'b1;
          wait_addr = imem_addr;
        end
      end
    end
    @(posedge clk);
    #1;
    if (valid_out && (!prev_valid || instruction !== prev_instr || pc_out !== prev_pc)) begin
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed instr %0d expected none", instruction);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_instr", instruction, e.instr);
        check("sb_pc", pc_out, e.pc);
      end
    end
    prev_valid = valid_out;
    prev_instr = instruction;
    prev_pc    = pc_out;
    imem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    waiting  = 1'b0;
    wait_cnt = 0;
    sb.delete();
    step(1'b0);
    rst     = 1'b0;
    freeze  = 1'b0;
    brTaken = 1'b0;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'd0);
  endtask

  initial begin
    // Zero-wait memory: one instruction per cycle.
    waits = 0;
    do_reset();
    step(1'b1);
    check("zw_valid1", {31'd0, valid_out}, 32'd1);
    check("zw_addr1", imem_addr, 32'd4);
    step(1'b1);
    check("zw_addr2", imem_addr, 32'd8);
    step(1'b1);
    check("zw_pc3", pc_out, 32'd12);
    check("zw_instr3", instruction, 32'd108);

    // Two wait states per fetch.
    waits = 2;
    do_reset();
    step(1'b1);
    check("ws_bubble1", {31'd0, valid_out}, 32'd0);
    step(1'b1);
    check("ws_bubble2", {31'd0, valid_out}, 32'd0);
    check("ws_bubble2_instr", instruction, 32'd0);
    step(1'b1);
    check("ws_first_valid", {31'd0, valid_out}, 32'd1);
    check("ws_first_instr", instruction, 32'd100);
    step(1'b1);
    check("ws_gap_valid", {31'd0, valid_out}, 32'd0);
    step(1'b1);
    step(1'b1);
    check("ws_second_instr", instruction, 32'd104);

    // Freeze for three cycles while the addr-8 ack arrives.
    waits = 0;
    do_reset();
    step(1'b1);
    step(1'b1);
    check("fz_pre_instr", instruction, 32'd104);
    check("fz_pre_addr", imem_addr, 32'd8);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("fz_keep_instr", instruction, 32'd104);
      check("fz_keep_pc", pc_out, 32'd8);
      check("fz_req_low", {31'd0, imem_req}, 32'd0);
    end
    freeze = 1'b0;
    step(1'b1);
    check("fz_rel_instr", instruction, 32'd108);
    check("fz_rel_pc", pc_out, 32'd12);
    check("fz_resume_addr", imem_addr, 32'd12);
    check("fz_resume_req", {31'd0, imem_req}, 32'd1);
    step(1'b1);
    check("fz_next_pc", pc_out, 32'd16);

    // Taken branch at pc_out=16, offset -2, zero-wait memory.
    brTaken   = 1'b1;
    br_offset = 32'hFFFF_FFFE;
    step(1'b0);
    brTaken = 1'b0;
    check("br_flush_valid", {31'd0, valid_out}, 32'd0);
    check("br_flush_instr", instruction, 32'd0);
    check("br_target_addr", imem_addr, 32'd8);
    step(1'b1);
    check("br_tgt_instr", instruction, 32'd108);

    // Taken branch during a 3-cycle wait on addr 20, target 40.
    waits = 0;
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1);
    check("dr_pre_addr", imem_addr, 32'd20);
    check("dr_pre_pc", pc_out, 32'd20);
    waits     = 3;
    brTaken   = 1'b1;
    br_offset = 32'd5;
    step(1'b0);
    brTaken = 1'b0;
    check("dr_flush_valid", {31'd0, valid_out}, 32'd0);
    check("dr_hold_addr", imem_addr, 32'd20);
    step(1'b0);
    step(1'b0);
    check("dr_wait_addr", imem_addr, 32'd20);
    check("dr_wait_valid", {31'd0, valid_out}, 32'd0);
    step(1'b0);
    check("dr_new_addr", imem_addr, 32'd40);
    check("dr_post_valid", {31'd0, valid_out}, 32'd0);
    waits = 0;
    step(1'b1);
    check("dr_tgt_instr", instruction, 32'd140);
    check("dr_tgt_pc", pc_out, 32'd44);

    // Reset while parked in HOLD, then again mid-wait.
    waits = 0;
    do_reset();
    step(1'b1);
    freeze = 1'b1;
    step(1'b1);
    check("rh_req_low", {31'd0, imem_req}, 32'd0);
    do_reset();
    step(1'b1);
    step(1'b1);
    check("rw_pre_addr", imem_addr, 32'd8);
    waits = 3;
    step(1'b0);
    step(1'b0);
    do_reset();
    waits = 0;
    step(1'b1);
    check("rw_restart_instr", instruction, 32'd100);
    check("rw_restart_pc", pc_out, 32'd4);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
